mult_appx_pipe: RTL

MULT_APPX_PIPE -- requirements
Module: mult_appx_pipe

---
 rtl/mult_appx_pkg.sv | 19 +
 rtl/mult_appx_lod.sv | 25 ++
 rtl/mult_appx_pipe.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mult_appx_pkg.sv
// Shared definitions for the approximate multiplier pipeline: the operating
// mode encoding, the result counter width and a mode classification helper.
package mult_appx_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_POW2  = 2'd1,
    MODE_TWO   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam int CNT_W = 16;

  // The reserved encoding behaves as exact, so only these two count as approximate.
  function automatic logic is_appx(input mode_e m);
    return (m == MODE_POW2) || (m == MODE_TWO);
  endfunction

endpackage

// File: rtl/mult_appx_lod.sv
// Combinational leading-one detector: reports the index of the most
// significant set bit of vec, and whether any bit is set at all.
module mult_appx_lod
  import mult_appx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int POS_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [POS_W-1:0] pos,
  output logic             found
);

  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        pos   = POS_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_appx_pipe.sv
// Three-stage valid/ready multiplier offering exact, nearest-power-of-two and
// two-term truncated products, plus a saturating count of approximate results.
module mult_appx_pipe
  import mult_appx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_y,
  output logic [1:0]         out_mode,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   appx_cnt
);

  localparam int POS_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  logic             s1_valid, s2_valid;
  logic             s2_ready, s3_ready;
  logic [WIDTH-1:0] s1_a, s1_b;
  mode_e            s1_mode, s2_mode;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [POS_W-1:0] s1_k, s1_p1, s1_p2;
  logic             s1_nz, s1_two;
  logic [PW-1:0]    s2_pp0, s2_pp1;

  logic [POS_W-1:0] p1, p2, k;
  logic             nz, two, rnd;
  logic [WIDTH-1:0] top_bit, b_rest;
  logic [PW-1:0]    a_ext, pp0, pp1;

  assign s3_ready = !out_valid || out_ready;
  assign s2_ready = !s2_valid || s3_ready;
  assign in_ready = !s1_valid || s2_ready;

  mult_appx_lod #(.WIDTH(WIDTH), .POS_W(POS_W)) u_lod_hi (
    .vec   (in_b),
    .pos   (p1),
    .found (nz)
  );

  assign top_bit = WIDTH'(1) << p1;
  assign b_rest  = in_b & ~top_bit;

  mult_appx_lod #(.WIDTH(WIDTH), .POS_W(POS_W)) u_lod_lo (
    .vec   (b_rest),
    .pos   (p2),
    .found (two)
  );

  // Nearest power of two: the bit just below the leading one decides round-up,
  // which also makes exact ties (b = 3*2^n) go to the larger power.
  always_comb begin
    rnd = |(in_b & (top_bit >> 1));
    k   = '0;
    if (nz) begin
      k = p1 + POS_W'(rnd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_EXACT;
      s1_tag   <= '0;
      s1_k     <= '0;
      s1_p1    <= '0;
      s1_p2    <= '0;
      s1_nz    <= 1'b0;
      s1_two   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= mode_e'(in_mode);
        s1_tag  <= in_tag;
        s1_k    <= k;
        s1_p1   <= p1;
        s1_p2   <= p2;
        s1_nz   <= nz;
        s1_two  <= two;
      end
    end
  end

  always_comb begin
    a_ext = PW'(s1_a);
    pp0   = '0;
    pp1   = '0;
    case (s1_mode)
      MODE_POW2: begin
        if (s1_nz) pp0 = a_ext << s1_k;
      end
      MODE_TWO: begin
        if (s1_nz)  pp0 = a_ext << s1_p1;
        if (s1_two) pp1 = a_ext << s1_p2;
      end
      default: pp0 = a_ext * PW'(s1_b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_pp0   <= '0;
      s2_pp1   <= '0;
      s2_mode  <= MODE_EXACT;
      s2_tag   <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pp0  <= pp0;
        s2_pp1  <= pp1;
        s2_mode <= s1_mode;
        s2_tag  <= s1_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_mode  <= '0;
      out_tag   <= '0;
    end else if (s3_ready) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_y    <= s2_pp0 + s2_pp1;
        out_mode <= s2_mode;
        out_tag  <= s2_tag;
      end
    end
  end

  // Clear takes priority over a coincident delivery; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      appx_cnt <= '0;
    end else if (cnt_clr) begin
      appx_cnt <= '0;
    end else if (out_valid && out_ready && is_appx(mode_e'(out_mode)) && (appx_cnt != '1)) begin
      appx_cnt <= appx_cnt + CNT_W'(1);
    end
  end

endmodule
